// File: rtl/flash_boot_copier_pkg.sv
// flash_boot_copier_pkg: shared bus widths, FSM encoding and flash/SRAM address helpers
package flash_boot_copier_pkg;
  localparam int WB_AddrBus = 32;
  localparam int WB_DataBus = 32;
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR, FIN} state_t;
  function automatic logic [WB_AddrBus-1:0] hw_addr(input logic [WB_AddrBus-1:0] base, input logic [15:0] n, input logic hi);
    return base + {13'b0, n, hi, 2'b0};
  endfunction
  function automatic logic [WB_AddrBus-1:0] word_addr(input logic [WB_AddrBus-1:0] base, input logic [15:0] n);
    return base + {14'b0, n, 2'b0};
  endfunction
endpackage

// File: rtl/flash_boot_copier_if.sv
// flash_boot_copier_if: start, flash read bus, SRAM write bus and status signals of the boot copier
interface flash_boot_copier_if;
  import flash_boot_copier_pkg::*;
  logic                  start_i;
  logic [WB_AddrBus-1:0] fl_addr_o;
  logic                  fl_select_o;
  logic                  fl_we_o;
  logic [WB_DataBus-1:0] fl_data_i;
  logic                  fl_ack_i;
  logic [WB_AddrBus-1:0] sr_addr_o;
  logic [WB_DataBus-1:0] sr_data_o;
  logic                  sr_select_o;
  logic                  sr_we_o;
  logic                  sr_ack_i;
  logic                  cpu_stall_o;
  logic                  done_o;
  logic                  error_o;
  modport master (
    input  start_i, fl_data_i, fl_ack_i, sr_ack_i,
    output fl_addr_o, fl_select_o, fl_we_o, sr_addr_o, sr_data_o, sr_select_o, sr_we_o,
           cpu_stall_o, done_o, error_o
  );
  modport slave (
    output start_i, fl_data_i, fl_ack_i, sr_ack_i,
    input  fl_addr_o, fl_select_o, fl_we_o, sr_addr_o, sr_data_o, sr_select_o, sr_we_o,
           cpu_stall_o, done_o, error_o
  );
endinterface

// File: rtl/flash_boot_copier_timer.sv
// boot_ack_timer: counts cycles a select is held without ack and flags the timeout cycle
module boot_ack_timer #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_busy,
  input  logic i_ack,
  output logic o_expired
);
  localparam int W = $clog2(ACK_TIMEOUT + 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= (rst || !i_busy || i_ack) ? '0 : r_cnt + 1'b1;
  assign o_expired = i_busy && !i_ack && r_cnt == W'(ACK_TIMEOUT - 1);
endmodule

// File: rtl/flash_boot_copier.sv
// flash_boot_copier: copies a 16-bit flash image into 32-bit SRAM words at boot or on start
module flash_boot_copier
  import flash_boot_copier_pkg::*;
#(
  parameter logic [WB_AddrBus-1:0] SRC_BASE    = 32'h1E00_0000,
  parameter logic [WB_AddrBus-1:0] DST_BASE    = 32'h0000_0000,
  parameter int                    WORD_COUNT  = 1024,
  parameter int                    ACK_TIMEOUT = 255
) (
  input logic                 clk,
  input logic                 rst,
  flash_boot_copier_if.master bus
);
  state_t                r_state;
  logic                  r_boot, r_fl_sel, r_sr_sel, r_done, r_err, r_stall;
  logic [15:0]           r_n;
  logic [WB_AddrBus-1:0] r_fl_addr, r_sr_addr;
  logic [WB_DataBus-1:0] r_data;
  logic                  w_busy, w_ack, w_expired, w_unused_hi;
  assign w_busy = r_fl_sel | r_sr_sel;
  assign w_ack = (r_fl_sel & bus.fl_ack_i) | (r_sr_sel & bus.sr_ack_i);
  assign w_unused_hi = ^bus.fl_data_i[31:16];
  boot_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
    .clk(clk), .rst(rst), .i_busy(w_busy), .i_ack(w_ack), .o_expired(w_expired)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_boot    <= 1'b1;
      r_n       <= '0;
      r_fl_sel  <= 1'b0;
      r_sr_sel  <= 1'b0;
      r_fl_addr <= '0;
      r_sr_addr <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_stall   <= 1'b1;
    end else if (w_expired) begin
      r_fl_sel <= 1'b0;
      r_sr_sel <= 1'b0;
      r_err    <= 1'b1;
      r_done   <= 1'b1;
      r_stall  <= 1'b0;
      r_state  <= FIN;
    end else begin
      case (r_state)
        IDLE: if (r_boot || bus.start_i) begin
          r_boot  <= 1'b0;
          r_n     <= '0;
          r_state <= RD_LO;
        end
        RD_LO, RD_HI: if (!r_fl_sel) begin
          r_fl_sel  <= 1'b1;
          r_fl_addr <= hw_addr(SRC_BASE, r_n, r_state == RD_HI);
        end else if (bus.fl_ack_i) begin
          r_fl_sel <= 1'b0;
          if (r_state == RD_LO) begin
            r_data[15:0] <= bus.fl_data_i[15:0];
            r_state      <= RD_HI;
          end else begin
            r_data[31:16] <= bus.fl_data_i[15:0];
            r_state       <= WR;
          end
        end
        WR: if (!r_sr_sel) begin
          r_sr_sel  <= 1'b1;
          r_sr_addr <= word_addr(DST_BASE, r_n);
        end else if (bus.sr_ack_i) begin
          r_sr_sel <= 1'b0;
          if (r_n == 16'(WORD_COUNT - 1)) begin
            r_done  <= 1'b1;
            r_stall <= 1'b0;
            r_state <= FIN;
          end else begin
            r_n     <= r_n + 16'd1;
            r_state <= RD_LO;
          end
        end
        FIN: if (bus.start_i) begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_n     <= '0;
          r_stall <= 1'b1;
          r_state <= RD_LO;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.fl_addr_o   = r_fl_addr;
  assign bus.fl_select_o = r_fl_sel;
  assign bus.fl_we_o     = 1'b0;
  assign bus.sr_addr_o   = r_sr_addr;
  assign bus.sr_data_o   = r_data;
  assign bus.sr_select_o = r_sr_sel;
  assign bus.sr_we_o     = r_sr_sel;
  assign bus.cpu_stall_o = r_stall;
  assign bus.done_o      = r_done;
  assign bus.error_o     = r_err;
endmodule
